// File: rtl/fp_align_shifter_if.sv
// fp_align_shifter_if
//   Groups the request/result signals of the exponent-alignment unit.
//   master : requester side (drives start/fraction/exp/targetExp, reads results)
//   slave  : alignment unit side (reads the request, drives the results)
//   Signals:
//     start        request strobe, sampled by the unit only while idle
//     fraction     operand fraction (hidden bit excluded)
//     exp          operand biased exponent
//     targetExp    exponent to align to
//     mantAligned  {hidden, fraction, G, R, S} after alignment
//     expAligned   exponent after alignment
//     busy         high while shifting
//     done         one-cycle result-valid pulse
//     err          operand exponent was larger than targetExp
interface fp_align_shifter_if #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 8
);
  logic              start;
  logic [FRAC_W-1:0] fraction;
  logic [EXP_W-1:0]  exp;
  logic [EXP_W-1:0]  targetExp;
  logic [FRAC_W+3:0] mantAligned;
  logic [EXP_W-1:0]  expAligned;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, fraction, exp, targetExp,
    input  mantAligned, expAligned, busy, done, err
  );

  modport slave (
    input  start, fraction, exp, targetExp,
    output mantAligned, expAligned, busy, done, err
  );
endinterface

// File: rtl/fp_align_shifter.sv
// fp_align_shifter
//   Iterative exponent-alignment (denormalization) unit for single-precision
//   add/sub. Right-shifts the smaller operand's significand one bit per clock
//   until its exponent reaches targetExp, keeping guard/round/sticky bits.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous active-high reset
//     bus    fp_align_shifter_if.slave (request inputs, aligned result outputs)
module fp_align_shifter #(
  parameter int FRAC_W = 23,
  parameter int EXP_W  = 8
) (
  input logic              clk,
  input logic              reset,
  fp_align_shifter_if.slave bus
);

  localparam int W = FRAC_W + 4;
  localparam logic [EXP_W:0] W_EXT = (EXP_W + 1)'(W);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [W-1:0]     mant;
  logic [EXP_W-1:0] expReg;
  logic [EXP_W:0]   count;
  logic             busyReg;
  logic             doneReg;
  logic             errReg;

  logic [W-1:0]     loadMant;
  logic [EXP_W:0]   diff;
  logic [W-1:0]     shiftMant;

  // Load value and unsigned difference. A zero exponent is a denormal, so
  // its hidden bit is 0. diff is one bit wider so exp > targetExp wraps
  // harmlessly; that case is caught by the explicit compare first.
  always_comb begin
    loadMant  = {(bus.exp != '0), bus.fraction, 3'b000};
    diff      = {1'b0, bus.targetExp} - {1'b0, bus.exp};
    shiftMant = {1'b0, mant[W-1:2], mant[1] | mant[0]};
  end

  assign bus.mantAligned = mant;
  assign bus.expAligned  = expReg;
  assign bus.busy        = busyReg;
  assign bus.done        = doneReg;
  assign bus.err         = errReg;

  // Single FSM: IDLE accepts a request and either finishes immediately
  // (error, no shift needed, or shift so large only sticky survives) or
  // enters SHIFT; SHIFT does one sticky-preserving right shift per clock;
  // DONE holds the done pulse for exactly one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      mant    <= '0;
      expReg  <= '0;
      count   <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
      errReg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          doneReg <= 1'b0;
          busyReg <= 1'b0;
          if (bus.start) begin
            errReg <= 1'b0;
            if (bus.exp > bus.targetExp) begin
              mant    <= loadMant;
              expReg  <= bus.exp;
              errReg  <= 1'b1;
              doneReg <= 1'b1;
              state   <= DONE;
            end else if (diff == '0) begin
              mant    <= loadMant;
              expReg  <= bus.exp;
              doneReg <= 1'b1;
              state   <= DONE;
            end else if (diff >= W_EXT) begin
              mant    <= {{(W-1){1'b0}}, |loadMant};
              expReg  <= bus.targetExp;
              doneReg <= 1'b1;
              state   <= DONE;
            end else begin
              mant    <= loadMant;
              expReg  <= bus.exp;
              count   <= diff;
              busyReg <= 1'b1;
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          mant   <= shiftMant;
          expReg <= expReg + 1'b1;
          count  <= count - 1'b1;
          if (count == (EXP_W + 1)'(1)) begin
            busyReg <= 1'b0;
            doneReg <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          doneReg <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          busyReg <= 1'b0;
          doneReg <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_align_shifter.sv
// tb_fp_align_shifter
//   Self-checking bench for fp_align_shifter. Expected results come from a
//   closed-form model (shift right by d, OR every discarded bit into bit 0)
//   and are queued when a request is driven, then popped when done appears.
module tb_fp_align_shifter;

  typedef struct packed {
    logic [26:0] m;
    logic [7:0]  x;
    logic        er;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t sb[$];

  fp_align_shifter_if #(.FRAC_W(23), .EXP_W(8)) bus ();

  fp_align_shifter #(.FRAC_W(23), .EXP_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: result of aligning, plus cycles from start edge to done.
  function automatic exp_t model(input logic [22:0] f, input logic [7:0] e,
                                 input logic [7:0] t);
    exp_t r;
    logic [63:0] m0;
    logic [63:0] mask;
    int d;
    m0 = {37'b0, (e != 8'd0), f, 3'b000};
    r.er = 1'b0;
    if (e > t) begin
      r.m = m0[26:0]; r.x = e; r.er = 1'b1; r.lat = 1;
    end else begin
      d = int'(t) - int'(e);
      r.x = t;
      if (d == 0) begin
        r.m = m0[26:0]; r.lat = 1;
      end else if (d >= 27) begin
        r.m = {26'b0, |m0}; r.lat = 1;
      end else begin
        mask = (64'd1 << d) - 64'd1;
        r.m = m0[26:0] >> d;
        r.m[0] = r.m[0] | (|(m0 & mask));
        r.lat = d + 1;
      end
    end
    return r;
  endfunction

  // Drives one request, scrambles inputs after the start edge, and waits
  // (bounded) for done. cyc = -1 on timeout.
  task automatic runOp(input logic [22:0] f, input logic [7:0] e, input logic [7:0] t,
                       output int cyc, output int busyCnt, output bit overlap);
    sb.push_back(model(f, e, t));
    @(negedge clk);
    bus.start = 1'b1; bus.fraction = f; bus.exp = e; bus.targetExp = t;
    @(negedge clk);
    bus.start = 1'b0;
    bus.fraction = 23'($urandom); bus.exp = 8'($urandom); bus.targetExp = 8'($urandom);
    cyc = -1; busyCnt = 0; overlap = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      if (bus.busy && bus.done) overlap = 1'b1;
      if (bus.busy) busyCnt++;
      if (bus.done) begin
        cyc = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.start = 1'b0;
    bus.fraction = '0; bus.exp = '0; bus.targetExp = '0;
    repeat (3) @(negedge clk);
    testsRun += 5;
    if (bus.mantAligned !== 27'd0) begin testsFailed++; $display("[TB] FAIL reset_mant got %h want 0", bus.mantAligned); end
    if (bus.expAligned !== 8'd0) begin testsFailed++; $display("[TB] FAIL reset_exp got %h want 0", bus.expAligned); end
    if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_done got %b want 0", bus.done); end
    if (bus.err !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_err got %b want 0", bus.err); end
    reset = 1'b0;
  endtask

  task automatic test_align_table;
    logic [22:0] fv [8] = '{23'h200000, 23'h000000, 23'h000001, 23'h123456,
                            23'h7FFFFF, 23'h0ABCDE, 23'h7FFFFF, 23'h000001};
    logic [7:0]  ev [8] = '{8'hC0, 8'h80, 8'h80, 8'h60, 8'h10, 8'h00, 8'h20, 8'h20};
    logic [7:0]  tv [8] = '{8'hC2, 8'h80, 8'h84, 8'h7E, 8'h2A, 8'h05, 8'h3B, 8'h3A};
    int cyc, bc;
    bit ov;
    exp_t ex;
    for (int i = 0; i < 8; i++) begin
      runOp(fv[i], ev[i], tv[i], cyc, bc, ov);
      ex = sb.pop_front();
      testsRun += 6;
      if (bus.mantAligned !== ex.m) begin testsFailed++; $display("[TB] FAIL align%0d_mant got %h want %h", i, bus.mantAligned, ex.m); end
      if (bus.expAligned !== ex.x) begin testsFailed++; $display("[TB] FAIL align%0d_exp got %h want %h", i, bus.expAligned, ex.x); end
      if (bus.err !== ex.er) begin testsFailed++; $display("[TB] FAIL align%0d_err got %b want %b", i, bus.err, ex.er); end
      if (cyc != ex.lat) begin testsFailed++; $display("[TB] FAIL align%0d_latency got %0d want %0d", i, cyc, ex.lat); end
      if (bc != ex.lat - 1 || ov) begin testsFailed++; $display("[TB] FAIL align%0d_busy got %0d cycles overlap %b want %0d cycles", i, bc, ov, ex.lat - 1); end
      @(negedge clk);
      if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL align%0d_pulse got done %b want 0", i, bus.done); end
    end
  endtask

  task automatic test_err;
    int cyc, bc;
    bit ov;
    exp_t ex;
    runOp(23'h345678, 8'h81, 8'h80, cyc, bc, ov);
    ex = sb.pop_front();
    testsRun += 4;
    if (bus.err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_flag got %b want 1", bus.err); end
    if (bus.mantAligned !== ex.m) begin testsFailed++; $display("[TB] FAIL err_mant got %h want %h", bus.mantAligned, ex.m); end
    if (bus.expAligned !== 8'h81) begin testsFailed++; $display("[TB] FAIL err_exp got %h want 81", bus.expAligned); end
    if (cyc != 1) begin testsFailed++; $display("[TB] FAIL err_latency got %0d want 1", cyc); end
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.err !== 1'b1) begin testsFailed++; $display("[TB] FAIL err_hold got %b want 1", bus.err); end
    runOp(23'h000010, 8'h40, 8'h43, cyc, bc, ov);
    ex = sb.pop_front();
    testsRun += 2;
    if (bus.err !== 1'b0) begin testsFailed++; $display("[TB] FAIL err_clear got %b want 0", bus.err); end
    if (bus.mantAligned !== ex.m) begin testsFailed++; $display("[TB] FAIL err_next_mant got %h want %h", bus.mantAligned, ex.m); end
  endtask

  task automatic test_start_ignored;
    exp_t ex;
    int cyc;
    sb.push_back(model(23'h000001, 8'h80, 8'h84));
    @(negedge clk);
    bus.start = 1'b1; bus.fraction = 23'h000001; bus.exp = 8'h80; bus.targetExp = 8'h84;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.fraction = 23'h7FFFFF; bus.exp = 8'h10; bus.targetExp = 8'h11;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = -1;
    for (int i = 3; i <= 64; i++) begin
      if (bus.done) begin cyc = i; break; end
      @(negedge clk);
    end
    ex = sb.pop_front();
    testsRun += 3;
    if (bus.mantAligned !== ex.m) begin testsFailed++; $display("[TB] FAIL restart_mant got %h want %h", bus.mantAligned, ex.m); end
    if (bus.expAligned !== ex.x) begin testsFailed++; $display("[TB] FAIL restart_exp got %h want %h", bus.expAligned, ex.x); end
    if (cyc != ex.lat) begin testsFailed++; $display("[TB] FAIL restart_latency got %0d want %0d", cyc, ex.lat); end
    repeat (3) @(negedge clk);
    testsRun++;
    if (bus.mantAligned !== ex.m) begin testsFailed++; $display("[TB] FAIL restart_hold got %h want %h", bus.mantAligned, ex.m); end
  endtask

  task automatic test_reset_mid_shift;
    bit sawDone;
    @(negedge clk);
    bus.start = 1'b1; bus.fraction = 23'h000001; bus.exp = 8'h80; bus.targetExp = 8'h84;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    testsRun += 5;
    if (bus.mantAligned !== 27'd0) begin testsFailed++; $display("[TB] FAIL abort_mant got %h want 0", bus.mantAligned); end
    if (bus.expAligned !== 8'd0) begin testsFailed++; $display("[TB] FAIL abort_exp got %h want 0", bus.expAligned); end
    if (bus.busy !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_busy got %b want 0", bus.busy); end
    if (bus.done !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_done got %b want 0", bus.done); end
    if (bus.err !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_err got %b want 0", bus.err); end
    sawDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done) sawDone = 1'b1;
    end
    testsRun++;
    if (sawDone) begin testsFailed++; $display("[TB] FAIL abort_no_done got done pulse want none"); end
  endtask

  task automatic test_back_to_back;
    logic [22:0] f;
    logic [7:0]  e, t;
    int cyc, bc;
    bit ov;
    exp_t ex;
    for (int i = 0; i < 20; i++) begin
      f = 23'($urandom);
      e = 8'($urandom_range(0, 200));
      t = (i % 5 == 4) ? 8'($urandom) : 8'(int'(e) + $urandom_range(0, 30));
      runOp(f, e, t, cyc, bc, ov);
      ex = sb.pop_front();
      testsRun += 4;
      if (bus.mantAligned !== ex.m) begin testsFailed++; $display("[TB] FAIL b2b%0d_mant got %h want %h", i, bus.mantAligned, ex.m); end
      if (bus.expAligned !== ex.x) begin testsFailed++; $display("[TB] FAIL b2b%0d_exp got %h want %h", i, bus.expAligned, ex.x); end
      if (bus.err !== ex.er) begin testsFailed++; $display("[TB] FAIL b2b%0d_err got %b want %b", i, bus.err, ex.er); end
      if (cyc != ex.lat || ov) begin testsFailed++; $display("[TB] FAIL b2b%0d_latency got %0d overlap %b want %0d", i, cyc, ov, ex.lat); end
    end
  endtask

  initial begin
    test_reset();
    test_align_table();
    test_err();
    test_start_ignored();
    test_reset_mid_shift();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
